// File: rtl/naive_bus_dma.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | naive_bus_dma : word-copy DMA master for the naive_bus (read, then write)  |
// | Optional grant timeout/abort: define NAIVE_BUS_DMA_TIMEOUT_EN.             |
// | Revision: 1.0                                                              |
// +---------------------------------------------------------------------------+
module naive_bus_dma #(
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             rd_req,
  output logic [3:0]       rd_be,
  output logic [31:0]      rd_addr,
  input  logic             rd_gnt,
  input  logic [31:0]      rd_data,
  output logic             wr_req,
  output logic [3:0]       wr_be,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  input  logic             wr_gnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_src, w_src_nxt;
  logic [31:0]      r_dst, w_dst_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic             r_rd_req, w_rd_req_nxt;
  logic             r_wr_req, w_wr_req_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;

`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              r_err, w_err_nxt;
  logic              w_timeout;
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1));
  wire w_unused = ^{src_addr[1:0], dst_addr[1:0]};
`else
  wire w_unused = ^{src_addr[1:0], dst_addr[1:0], (TIMEOUT_CYCLES != 0)};
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_src_nxt    = r_src;
    w_dst_nxt    = r_dst;
    w_data_nxt   = r_data;
    w_rem_nxt    = r_rem;
    w_rd_req_nxt = r_rd_req;
    w_wr_req_nxt = r_wr_req;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
    w_wait_nxt   = r_wait;
    w_err_nxt    = r_err;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_src_nxt  = {src_addr[31:2], 2'b00};
          w_dst_nxt  = {dst_addr[31:2], 2'b00};
          w_rem_nxt  = len;
          w_busy_nxt = 1'b1;
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
          w_err_nxt  = 1'b0;
          w_wait_nxt = '0;
`endif
          if (len == '0) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt  = RD;
            w_rd_req_nxt = 1'b1;
          end
        end
      end
      RD: begin
        if (rd_gnt) begin
          w_rd_req_nxt = 1'b0;
          w_state_nxt  = RD_WAIT;
        end
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
        else if (w_timeout) begin
          w_rd_req_nxt = 1'b0;
          w_err_nxt    = 1'b1;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = FIN;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
`endif
      end
      RD_WAIT: begin
        // Slave data is valid exactly one cycle after the grant.
        w_data_nxt   = rd_data;
        w_wr_req_nxt = 1'b1;
        w_state_nxt  = WR;
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
        w_wait_nxt   = '0;
`endif
      end
      WR: begin
        if (wr_gnt) begin
          w_wr_req_nxt = 1'b0;
          w_src_nxt    = r_src + 32'd4;
          w_dst_nxt    = r_dst + 32'd4;
          w_rem_nxt    = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = FIN;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
          end else begin
            w_state_nxt  = RD;
            w_rd_req_nxt = 1'b1;
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
            w_wait_nxt   = '0;
`endif
          end
        end
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
        else if (w_timeout) begin
          w_wr_req_nxt = 1'b0;
          w_err_nxt    = 1'b1;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = FIN;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
`endif
      end
      FIN: begin
        // Entered either with done already raised (after the last word or an
        // abort) or straight from IDLE for a zero-length copy.
        if (r_done) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_done_nxt = 1'b1;
          w_busy_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_data   <= '0;
      r_rem    <= '0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
      r_wait   <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_src    <= w_src_nxt;
      r_dst    <= w_dst_nxt;
      r_data   <= w_data_nxt;
      r_rem    <= w_rem_nxt;
      r_rd_req <= w_rd_req_nxt;
      r_wr_req <= w_wr_req_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
      r_wait   <= w_wait_nxt;
      r_err    <= w_err_nxt;
`endif
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_req  = r_rd_req;
  assign rd_be   = {4{r_rd_req}};
  assign rd_addr = r_src;
  assign wr_req  = r_wr_req;
  assign wr_be   = {4{r_wr_req}};
  assign wr_addr = r_dst;
  assign wr_data = r_data;
`ifdef NAIVE_BUS_DMA_TIMEOUT_EN
  assign err     = r_err;
`else
  assign err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_naive_bus_dma.sv
`default_nettype none
// Bench for naive_bus_dma: slave models plus a transfer-level scoreboard
// (expected read/write queues and busy/done windows) checked every cycle.
module tb_naive_bus_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic        rd_req, wr_req, rd_gnt = 1'b0, wr_gnt = 1'b0;
  logic [3:0]  rd_be, wr_be;
  logic [31:0] rd_addr, rd_data = '0, wr_addr, wr_data;

  naive_bus_dma #(.LEN_W(16), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_be(rd_be), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .wr_req(wr_req), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt)
  );

  always #5 clk = ~clk;

  int n_err = 0, n_chk = 0, cyc = 0;
  int dr = 0, dw = 0, rd_wait = 0, wr_wait = 0;
  bit m_active = 0;
  int m_t0 = 0, m_T = 0;
  logic [31:0] q_rd[$], q_wa[$], q_wd[$];
  int n_rd = 0, n_wr = 0, done_pulses = 0, busy_rise = 0, done_cyc = 0, start_cyc = 0;
  logic [31:0] last_rd = '0, last_wa = '0, g_rd_addr = '0;
  logic prev_busy = 0, prev_rd_req = 0, prev_wr_req = 0;
  logic [31:0] prev_rd_addr = '0, prev_wa = '0, prev_wd = '0;

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Compare process and slave models, evaluated on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd_gnt = 0; wr_gnt = 0; rd_wait = 0; wr_wait = 0; rd_data = '0;
        prev_busy = 0; prev_rd_req = 0; prev_wr_req = 0;
        continue;
      end
      chk("req_exclusive", {31'd0, rd_req & wr_req}, 32'd0);
      chk("busy", {31'd0, busy}, {31'd0, m_active && cyc >= m_t0 && cyc < m_t0 + m_T});
      chk("done", {31'd0, done}, {31'd0, m_active && cyc == m_t0 + m_T});
      chk("err", {31'd0, err}, 32'd0);
      if (busy && !prev_busy) busy_rise = cyc;
      if (done) begin done_pulses++; done_cyc = cyc; end
      if (rd_req) chk("rd_be", {28'd0, rd_be}, 32'hF);
      if (wr_req) chk("wr_be", {28'd0, wr_be}, 32'hF);
      if (rd_req && prev_rd_req) chk("rd_addr_stable", rd_addr, prev_rd_addr);
      if (wr_req && prev_wr_req) begin
        chk("wr_addr_stable", wr_addr, prev_wa);
        chk("wr_data_stable", wr_data, prev_wd);
      end
      // read slave
      if (rd_gnt) begin
        rd_data = fdat(g_rd_addr);
        rd_gnt  = 0;
      end else begin
        rd_data = 32'hDEADBEEF;
        if (rd_req) begin
          if (rd_wait >= dr) begin
            rd_gnt = 1; rd_wait = 0; g_rd_addr = rd_addr;
            n_rd++; last_rd = rd_addr;
            if (q_rd.size() == 0) fail_now("rd_unexpected");
            else chk("rd_addr", rd_addr, q_rd.pop_front());
          end else rd_wait++;
        end
      end
      // write slave
      if (wr_gnt) wr_gnt = 0;
      else if (wr_req) begin
        if (wr_wait >= dw) begin
          wr_gnt = 1; wr_wait = 0;
          n_wr++; last_wa = wr_addr;
          if (q_wa.size() == 0) fail_now("wr_unexpected");
          else begin
            chk("wr_addr", wr_addr, q_wa.pop_front());
            chk("wr_data", wr_data, q_wd.pop_front());
          end
        end else wr_wait++;
      end
      if (m_active && cyc == m_t0 + m_T) begin
        chk("reads_left", q_rd.size(), 0);
        chk("writes_left", q_wa.size(), 0);
        m_active = 0;
      end
      prev_busy = busy; prev_rd_req = rd_req; prev_wr_req = wr_req;
      prev_rd_addr = rd_addr; prev_wa = wr_addr; prev_wd = wr_data;
    end
  end

  task automatic xfer_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                            input bit model_it);
    logic [31:0] sa, da;
    @(negedge clk); #1;
    src_addr = s; dst_addr = d; len = n; start = 1'b1;
    if (model_it) begin
      start_cyc = cyc;
      sa = {s[31:2], 2'b00};
      da = {d[31:2], 2'b00};
      q_rd.delete(); q_wa.delete(); q_wd.delete();
      for (int i = 0; i < int'(n); i++) begin
        q_rd.push_back(sa + 32'(4 * i));
        q_wa.push_back(da + 32'(4 * i));
        q_wd.push_back(fdat(sa + 32'(4 * i)));
      end
      n_rd = 0; n_wr = 0; done_pulses = 0;
      m_t0 = cyc + 1;
      m_T  = (n == 0) ? 1 : int'(n) * (3 + dr + dw);
      m_active = 1;
    end
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!m_active) return;
      @(negedge clk); #1;
    end
    fail_now("transfer_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk("rst_rd_addr", rd_addr, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_be", {24'd0, rd_be, wr_be}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 4 words, zero-wait slaves
    dr = 0; dw = 0;
    xfer_start(32'h0, 32'h00010000, 16'd4, 1);
    wait_done(200);
    chk("t1_writes", n_wr, 4);
    chk("t1_last_wa", last_wa, 32'h0001000C);
    chk("t1_last_rd", last_rd, 32'h0000000C);
    chk("t1_latency", done_cyc - busy_rise, 12);
    chk("t1_done_pulses", done_pulses, 1);

    // zero length
    xfer_start(32'h100, 32'h200, 16'd0, 1);
    wait_done(50);
    repeat (3) @(negedge clk);
    chk("t2_done_delay", done_cyc - start_cyc, 2);
    chk("t2_reads", n_rd, 0);
    chk("t2_writes", n_wr, 0);

    // read slave stalls 5 cycles per request
    dr = 5; dw = 0;
    xfer_start(32'h400, 32'h800, 16'd2, 1);
    wait_done(200);
    chk("t3_done_pulses", done_pulses, 1);
    chk("t3_latency", done_cyc - busy_rise, 16);

    // start during transfer is ignored
    dr = 1; dw = 0;
    xfer_start(32'h100, 32'h900, 16'd3, 1);
    xfer_start(32'h2000, 32'h7000, 16'd5, 0);
    wait_done(200);
    repeat (4) @(negedge clk);
    chk("t4_writes", n_wr, 3);
    chk("t4_last_rd", last_rd, 32'h00000108);

    // address wrap with unaligned inputs
    dr = 0; dw = 2;
    xfer_start(32'hFFFFFFF9, 32'h00003003, 16'd3, 1);
    wait_done(200);
    chk("t5_last_rd", last_rd, 32'h00000000);
    chk("t5_last_wa", last_wa, 32'h00003008);

    // start coinciding with the done cycle is ignored
    dr = 0; dw = 0;
    xfer_start(32'h40, 32'h60, 16'd2, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    src_addr = 32'h3000; len = 16'd2; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("t6_reads", n_rd, 2);
    chk("t6_done_pulses", done_pulses, 1);

    // reset during WR of word 2 of 4
    dr = 0; dw = 3;
    xfer_start(32'h500, 32'h600, 16'd4, 1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (wr_req && n_wr == 1) break;
    end
    chk("t7_in_wr2", {31'd0, wr_req}, 32'd1);
    #1;
    rst = 1'b1;
    m_active = 0;
    q_rd.delete(); q_wa.delete(); q_wd.delete();
    done_pulses = 0;
    #1;
    chk("t7_wr_req_drop", {31'd0, wr_req}, 32'd0);
    chk("t7_busy_drop", {31'd0, busy}, 32'd0);
    chk("t7_no_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("t7_no_done_after", done_pulses, 0);
    dr = 2; dw = 1;
    xfer_start(32'h40, 32'h80, 16'd2, 1);
    wait_done(200);
    chk("t7_writes", n_wr, 2);
    chk("t7_last_wa", last_wa, 32'h00000084);
    chk("t7_done_pulses", done_pulses, 1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
